// File: rtl/seq_match_ctrl_pkg.sv
// Shared types and constants for the serial pattern-match controller.
package seq_match_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int              MAX_LEN     = 5;
  localparam int              CNT_W       = 8;
  localparam logic [MAX_LEN-1:0] DEF_PATTERN = 5'b10010;
  localparam logic [2:0]      DEF_LEN     = 3'd5;

  // Active match configuration; len is always normalized to 1..MAX_LEN.
  typedef struct packed {
    logic [MAX_LEN-1:0] pattern;
    logic [2:0]         len;
  } match_cfg_t;

  // Out-of-range lengths fall back to the full history width.
  function automatic logic [2:0] norm_len(input logic [2:0] l);
    return (l == 3'd0 || l > 3'(MAX_LEN)) ? 3'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Byte, configuration and status signals of the pattern-match controller.
interface seq_match_ctrl_if;
  import seq_match_ctrl_pkg::*;

  logic             cfg_we;
  logic [4:0]       cfg_pattern;
  logic [2:0]       cfg_len;
  logic [7:0]       cfg_thresh;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             irq;
  logic             irq_clr;
  logic             busy;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_data, irq_clr,
    input  in_ready, hit, hit_count, irq, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_thresh, in_valid, in_data, irq_clr,
    output in_ready, hit, hit_count, irq, busy
  );
endinterface

// File: rtl/seq_bit_matcher.sv
// Bit history, fill tracking and registered pattern compare.
module seq_bit_matcher
  import seq_match_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       data_bit,
  input  match_cfg_t cfg,
  input  logic       clear,
  output logic       hit
);

  logic [MAX_LEN-1:0] hist, hist_nx, mask;
  logic [2:0]         fill, fill_nx;
  logic               match;

  // Compare against the history as it will look after this bit lands.
  always_comb begin
    hist_nx = MAX_LEN'({hist, data_bit});
    fill_nx = (fill == 3'(MAX_LEN)) ? fill : fill + 3'd1;
    mask    = MAX_LEN'((6'd1 << cfg.len) - 6'd1);
    match   = (fill_nx >= cfg.len) && (((hist_nx ^ cfg.pattern) & mask) == '0);
  end

  // History persists across bytes; only a config write or reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      hit  <= 1'b0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
      hit  <= 1'b0;
    end else if (bit_valid) begin
      hist <= hist_nx;
      fill <= fill_nx;
      hit  <= match;
    end else begin
      hit  <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Byte serializer feeding a sliding bit-pattern matcher, with hit counter and irq.
module seq_match_ctrl
  import seq_match_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  seq_match_ctrl_if.slave bus
);

  state_t           state, state_nx;
  logic [7:0]       data_q;
  logic [2:0]       idx;
  match_cfg_t       cfg_q;
  logic [7:0]       thresh_q;
  logic [CNT_W-1:0] cnt, cnt_inc, cnt_nx;
  logic             irq_q, irq_nx;
  logic             ready, busy_w, accept, cfg_take, hit;

  assign accept   = bus.in_valid && (state == IDLE);
  assign cfg_take = bus.cfg_we   && (state == IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy_w   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        busy_w = 1'b1;
        if (idx == 3'd0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte capture and MSB-first bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      idx    <= '0;
    end else if (accept) begin
      data_q <= bus.in_data;
      idx    <= 3'd7;
    end else if (state == SHIFT && idx != 3'd0) begin
      idx    <= idx - 3'd1;
    end
  end

  // Configuration is only taken between bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q.pattern <= DEF_PATTERN;
      cfg_q.len     <= DEF_LEN;
      thresh_q      <= '0;
    end else if (cfg_take) begin
      cfg_q.pattern <= bus.cfg_pattern;
      cfg_q.len     <= norm_len(bus.cfg_len);
      thresh_q      <= bus.cfg_thresh;
    end
  end

  seq_bit_matcher u_match (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (state == SHIFT),
    .data_bit  (data_q[idx]),
    .cfg       (cfg_q),
    .clear     (cfg_take),
    .hit       (hit)
  );

  // Saturating count; irq_clr restarts the count but still counts a coincident hit.
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    cnt_nx  = bus.irq_clr ? CNT_W'(hit) : (hit ? cnt_inc : cnt);
    irq_nx  = (bus.irq_clr ? 1'b0 : irq_q) |
              (hit && thresh_q != '0 && cnt_nx == thresh_q);
  end

  // Counter and interrupt registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt   <= cnt_nx;
      irq_q <= irq_nx;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.busy      = busy_w;
  assign bus.hit       = hit;
  assign bus.hit_count = cnt;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, random run vs stream model.
module tb_seq_match_ctrl;

  logic clk = 1'b0;
  logic rst;
  seq_match_ctrl_if bus();

  seq_match_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: pending bits of the current byte, and the bit stream since config.
  int m_pend[$];
  int m_hist[$];
  int m_nbits, m_cnt, m_pat, m_len, m_thr;
  int m_hit, m_irq;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_match();
    int v = 0;
    if (m_nbits < m_len) return 0;
    for (int i = m_hist.size() - m_len; i < m_hist.size(); i++) v = v * 2 + m_hist[i];
    return (v == (m_pat % (1 << m_len))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_pend.delete(); m_hist.delete();
    m_nbits = 0; m_cnt = 0; m_hit = 0; m_irq = 0;
    m_pat = 5'b10010; m_len = 5; m_thr = 0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_edge();
    int old_hit = m_hit;
    int old_thr = m_thr;
    int nc;
    if (m_pend.size() > 0) begin
      m_hist.push_back(m_pend.pop_front());
      if (m_hist.size() > 5) void'(m_hist.pop_front());
      m_nbits++;
      m_hit = model_match();
    end else begin
      m_hit = 0;
      if (bus.cfg_we) begin
        m_pat = int'(bus.cfg_pattern);
        m_len = (bus.cfg_len == 0 || bus.cfg_len > 5) ? 5 : int'(bus.cfg_len);
        m_thr = int'(bus.cfg_thresh);
        m_hist.delete();
        m_nbits = 0;
      end
      if (bus.in_valid)
        for (int b = 7; b >= 0; b--) m_pend.push_back(int'(bus.in_data[b]));
    end
    nc = old_hit ? ((m_cnt == 255) ? 255 : m_cnt + 1) : m_cnt;
    if (bus.irq_clr) nc = old_hit;
    m_irq = (bus.irq_clr ? 0 : m_irq) | ((old_hit && old_thr != 0 && nc == old_thr) ? 1 : 0);
    m_cnt = nc;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},  int'(bus.in_ready),  (m_pend.size() == 0) ? 1 : 0);
    check({tag, ".busy"},      int'(bus.busy),      (m_pend.size() != 0) ? 1 : 0);
    check({tag, ".hit"},       int'(bus.hit),       m_hit);
    check({tag, ".hit_count"}, int'(bus.hit_count), m_cnt);
    check({tag, ".irq"},       int'(bus.irq),       m_irq);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all("model");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_thresh = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.irq_clr = 0;
  endtask

  // Config write plus counter clear in one idle cycle.
  task automatic configure(input logic [4:0] p, input logic [2:0] l, input logic [7:0] t);
    bus.cfg_we = 1; bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_thresh = t; bus.irq_clr = 1;
    tick();
    bus.cfg_we = 0; bus.irq_clr = 0;
  endtask

  // Offer one byte, run it out, and leave one idle cycle so the last hit is counted.
  task automatic send_byte(input logic [7:0] b, output int hits);
    bus.in_data = b; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    hits = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (bus.hit) hits++;
    end
  endtask

  typedef struct {
    logic [4:0] pat;
    logic [2:0] len;
    logic [7:0] thr;
    logic [7:0] data;
    int         hits;
    int         cnt;
    int         irq;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int h, tot;
    tbl[0] = '{5'b10010, 3'd5, 8'd0, 8'h92, 2, 2, 0};
    tbl[1] = '{5'b00001, 3'd2, 8'd3, 8'h55, 4, 4, 1};
    tbl[2] = '{5'b11111, 3'd0, 8'd0, 8'hFF, 4, 4, 0};
    tbl[3] = '{5'b00001, 3'd1, 8'd0, 8'hA5, 4, 4, 0};
    tbl[4] = '{5'b10101, 3'd7, 8'd2, 8'hAA, 2, 2, 1};
    tbl[5] = '{5'b00000, 3'd3, 8'd1, 8'h00, 6, 6, 1};

    idle_inputs();
    do_reset();

    // Reset defaults with 0x92: hits after bits 5 and 8, ready back after bit 8.
    bus.in_data = 8'h92; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    check("d92.busy_after_accept", int'(bus.busy), 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("d92.hit_bit%0d", k), int'(bus.hit), (k == 5 || k == 8) ? 1 : 0);
      check($sformatf("d92.ready_bit%0d", k), int'(bus.in_ready), (k == 8) ? 1 : 0);
    end
    tick();
    check("d92.hit_count", int'(bus.hit_count), 2);

    // Table of single-byte vectors, each from a freshly written config.
    for (int i = 0; i < 6; i++) begin
      configure(tbl[i].pat, tbl[i].len, tbl[i].thr);
      send_byte(tbl[i].data, h);
      check($sformatf("tbl%0d.hits", i), h, tbl[i].hits);
      check($sformatf("tbl%0d.hit_count", i), int'(bus.hit_count), tbl[i].cnt);
      check($sformatf("tbl%0d.irq", i), int'(bus.irq), tbl[i].irq);
    end

    // Match spanning the byte boundary: 0x09 then 0x00.
    configure(5'b10010, 3'd5, 8'd0);
    send_byte(8'h09, h);
    check("span.first_byte_hits", h, 0);
    bus.in_data = 8'h00; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick();
    check("span.hit_first_bit", int'(bus.hit), 1);
    h = 0;
    for (int k = 2; k <= 9; k++) begin
      tick();
      if (bus.hit) h++;
    end
    check("span.later_hits", h, 0);
    check("span.hit_count", int'(bus.hit_count), 1);

    // irq_clr coincident with a hit: count restarts at 1, irq drops (thresh 2).
    configure(5'b00001, 3'd1, 8'd2);
    bus.in_data = 8'hE0; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick(); tick(); tick();
    check("clr.pre_irq", int'(bus.irq), 1);
    check("clr.pre_hit", int'(bus.hit), 1);
    bus.irq_clr = 1;
    tick();
    bus.irq_clr = 0;
    check("clr.hit_count", int'(bus.hit_count), 1);
    check("clr.irq", int'(bus.irq), 0);
    for (int k = 5; k <= 9; k++) tick();

    // Saturation: 130 x 0x92 gives 260 hits, count pinned at 255.
    configure(5'b10010, 3'd5, 8'd0);
    tot = 0;
    for (int i = 0; i < 130; i++) begin
      send_byte(8'h92, h);
      tot += h;
    end
    check("sat.total_hits", tot, 260);
    check("sat.last_byte_hits", h, 2);
    check("sat.hit_count", int'(bus.hit_count), 255);

    // Config write during SHIFT is ignored.
    configure(5'b10010, 3'd5, 8'd0);
    bus.in_data = 8'h92; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tick();
    bus.cfg_we = 1; bus.cfg_pattern = 5'b00001; bus.cfg_len = 3'd1; bus.cfg_thresh = 8'd1;
    tick();
    idle_inputs();
    h = 0;
    for (int k = 3; k <= 9; k++) begin
      tick();
      if (bus.hit) h++;
    end
    check("cfgbusy.hits", h, 2);
    check("cfgbusy.irq", int'(bus.irq), 0);
    send_byte(8'h92, h);
    check("cfgbusy.next_hits", h, 2);

    // Reset after the 4th bit discards the byte.
    bus.in_data = 8'h92; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    h = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.hit) h++;
    end
    do_reset();
    check("rstmid.hits", h, 0);
    check("rstmid.hit_after", int'(bus.hit), 0);
    check("rstmid.ready", int'(bus.in_ready), 1);
    send_byte(8'h92, h);
    check("rstmid.next_hits", h, 2);

    // Random traffic against the stream model.
    configure(5'b00101, 3'd3, 8'd4);
    for (int c = 0; c < 600; c++) begin
      bus.in_valid    = ($urandom % 2) == 0;
      bus.in_data     = 8'($urandom);
      bus.cfg_we      = ($urandom % 20) == 0;
      bus.cfg_pattern = 5'($urandom);
      bus.cfg_len     = 3'($urandom);
      bus.cfg_thresh  = 8'($urandom_range(0, 6));
      bus.irq_clr     = ($urandom % 25) == 0;
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
